// File: rtl/uart_rx.sv
// uart_rx: MSB-first asynchronous serial receiver, the receive-side partner of uart_tx.
// The bit period and stop-bit mode are latched at each start bit.
module uart_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [15:0] bit_duration,
    input  logic [1:0]  stopbits,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        framing_error,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, STARTBIT, DATABITS, STOPBIT, WAITHIGH} state_t;

    state_t      state;
    logic [15:0] ctr;
    logic [15:0] bd_q;
    logic [1:0]  sb_q;
    logic [2:0]  bit_ctr;
    logic [7:0]  shreg;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_sync_d;
    logic [1:0]  sync_fill;
    logic        armed;
    logic [15:0] stop_point;

    // The synchroniser resets high, so a line already low at reset release would look
    // like a falling edge; armed stays low until a genuine high has come through.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & rx_sync);
        end
    end

    assign stop_point = (sb_q == 2'b00) ? ((bd_q >> 1) + (bd_q >> 2)) : bd_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ctr           <= '0;
            bit_ctr       <= '0;
            shreg         <= '0;
            bd_q          <= '0;
            sb_q          <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    ctr     <= '0;
                    bit_ctr <= '0;
                    if (armed && !rx_sync && rx_sync_d) begin
                        bd_q  <= bit_duration;
                        sb_q  <= stopbits;
                        state <= STARTBIT;
                    end
                end
                STARTBIT: begin
                    if (ctr == (bd_q >> 1)) begin
                        ctr   <= '0;
                        state <= rx_sync ? IDLE : DATABITS;
                    end else begin
                        ctr <= ctr + 16'd1;
                    end
                end
                DATABITS: begin
                    if (ctr == bd_q) begin
                        shreg   <= {shreg[6:0], rx_sync};
                        ctr     <= '0;
                        bit_ctr <= bit_ctr + 3'd1;
                        if (bit_ctr == 3'd7)
                            state <= STOPBIT;
                    end else begin
                        ctr <= ctr + 16'd1;
                    end
                end
                STOPBIT: begin
                    if (ctr == stop_point) begin
                        data <= shreg;
                        if (rx_sync) begin
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAITHIGH;
                        end
                    end else begin
                        ctr <= ctr + 16'd1;
                    end
                end
                // A held-low break must not be mistaken for the next start bit.
                WAITHIGH: begin
                    if (rx_sync)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver and the receive-side counterpart of the team's `uart_tx`. It deserialises one 8-bit frame per start bit from the `rx` line, most-significant data bit first, using the same `bit_duration` and `stopbits` encodings as `uart_tx`. It presents each byte on `data` with a one-cycle `data_valid` strobe and flags stop-bit violations on `framing_error`. It sits between the board RX pin and the host-side byte consumer.

## Interface
- No parameters. Widths are fixed to match `uart_tx`.
- `clk` input 1: the single clock. Everything is `posedge clk`.
- `rst` input 1: reset, synchronous, active-high.
- `rx` input 1: serial line. Asynchronous to `clk`. Idles high.
- `bit_duration` input 16: bit period minus one, in `clk` cycles, so P = `bit_duration`+1. It is captured at start detection.
- `stopbits` input 2: 00 = 0.5, 01 = 1, 10 = 1.5, 11 = 2 stop bits. It is captured at start detection.
- `data` output 8: last received byte. It holds until the next frame completes.
- `data_valid` output 1: one-cycle pulse when a good frame is loaded into `data`.
- `framing_error` output 1: one-cycle pulse when the stop-bit sample is 0.
- `busy` output 1: high in every state except IDLE.

## Operation
- Synchroniser: `rx` passes through two flops to give `rx_sync`, then a third flop gives `rx_sync_d`. All three flops reset to 1.
- States (3-bit): IDLE, STARTBIT, DATABITS, STOPBIT, WAITHIGH.
- IDLE
  - Clears `ctr` and `bit_ctr`.
  - When `rx_sync`==0 and `rx_sync_d`==1 (falling edge): captures `bit_duration` into `bd_q` and `stopbits` into `sb_q`, then moves to STARTBIT with `ctr`=0.
  - A line that is already low at reset release, or a line stuck low, never starts a frame.
- STARTBIT
  - `ctr` increments each cycle.
  - At `ctr`==`bd_q`>>1 (mid start bit), `rx_sync` is sampled:
    - 1: false start. Go to IDLE with no output pulse.
    - 0: clear `ctr` and go to DATABITS.
- DATABITS
  - `ctr` increments each cycle.
  - At `ctr`==`bd_q`: `shreg` <= {`shreg`[6:0], `rx_sync`}, `ctr` <= 0, and `bit_ctr` increments.
  - The first received bit ends up in `shreg`[7], matching the MSB-first order of `uart_tx`.
  - After the 8th sample, go to STOPBIT.
- STOPBIT: `ctr` increments each cycle. The stop sample is taken at a point set by `sb_q`:
  - 01, 10, 11: at `ctr`==`bd_q`, the middle of the first stop bit.
  - 00: at `ctr`==(`bd_q`>>1)+(`bd_q`>>2), the middle of the half stop bit.
  - Only the first stop bit is checked. Any extra stop time is absorbed in IDLE.
- Result of the stop sample:
  - 1: `data` <= `shreg`, `data_valid` <= 1, go to IDLE.
  - 0: `data` <= `shreg`, `framing_error` <= 1, go to WAITHIGH.
- WAITHIGH: stays until `rx_sync`==1, then goes to IDLE. This keeps a break condition (line held low) from being decoded as a start.
- Arithmetic: `ctr` is 16 bits. Comparisons are equality against `bd_q`-derived values, and shifts truncate.
  - With `bd_q`=0, the half-period sample happens at `ctr`==0. Sampling occurs every cycle with no error.
  - `bd_q`=0 is legal but not guaranteed accurate.

## Timing
- Reset values:
  - Outputs: `data`=0x00, `data_valid`=0, `framing_error`=0, `busy`=0.
  - Internal: state IDLE, `ctr`=0, `bit_ctr`=0, `shreg`=0.
- Reset mid-frame abandons the frame on the next edge. No pulse is emitted.
- `data_valid` and `framing_error` are registered, high for exactly one cycle, and never high together.
- Detection latency: if `rx` is first sampled low at edge A, the FSM leaves IDLE at edge E0 = A+2.
- Sample edges, with h=`bd_q`>>1:
  - Start bit: E0+h+1.
  - Data bit i (i=0..7): E0+h+1+(i+1)·P.
  - Stop bit (01/10/11): E0+h+1+9·P.
- `data_valid` is visible in the cycle after the stop-sampling edge. It falls one cycle later.
- Back-to-back frames: IDLE is reached at mid stop bit, so a start bit arriving right after the stop time is detected normally.
- Input changes to `bit_duration` or `stopbits` mid-frame have no effect until the next start.

## Test plan
- **Basic byte:** `bit_duration`=15, `stopbits`=01, drive 0xA5 MSB-first at 16 cycles/bit -> one `data_valid` pulse, `data`=0xA5, `framing_error` stays 0, `busy` returns to 0.
- **Loopback:** connect `uart_tx` to `uart_rx`. Send 0x00, 0xFF, 0x3C back-to-back with each `stopbits` value 00..11 -> three `data_valid` pulses per mode, bytes match in order.
- **False start:** 4-cycle low glitch, `bit_duration`=15 -> no pulse, FSM returns to IDLE, and a following 0x81 frame is received correctly.
- **Framing error:** 0x5A frame with the stop bit driven low, then the line held low for 40 cycles -> `framing_error` pulses once, `data`=0x5A, no `data_valid`, no new frame until `rx` returns high.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 -> outputs at reset values, no pulse, next 0xC3 frame received.
- **Capture check:** change `bit_duration` from 15 to 7 during a frame -> the current frame still decodes at P=16, and the next frame decodes at P=8.
